// File: rtl/mod_ctrl_pkg.sv
// Shared definitions for the modulator select sequencer: register map, FSM states,
// waveform/modulation index constants.
package mod_ctrl_pkg;

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_SEL   = 2'd1;
    localparam logic [1:0] ADDR_DWELL = 2'd2;
    localparam logic [1:0] ADDR_STAT  = 2'd3;

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        ARMED  = 2'd1,
        AUTO   = 2'd2
    } seq_state_e;

    localparam logic [7:0] SIG_SIN = 8'd0;
    localparam logic [7:0] SIG_COS = 8'd1;
    localparam logic [7:0] SIG_SQU = 8'd2;
    localparam logic [7:0] SIG_SAW = 8'd3;

    localparam logic [3:0] MOD_ASK  = 4'd0;
    localparam logic [3:0] MOD_BPSK = 4'd1;
    localparam logic [3:0] MOD_FSK  = 4'd2;

endpackage

// File: rtl/modulator_select_sequencer_if.sv
// Avalon-MM register port of the sequencer; master = bus host, slave = sequencer.
interface modulator_select_sequencer_if;

    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;

    modport master (
        output address,
        output write,
        output writedata,
        output read,
        input  readdata
    );

    modport slave (
        input  address,
        input  write,
        input  writedata,
        input  read,
        output readdata
    );

endinterface

// File: rtl/mod_sel_regfile.sv
// Avalon-MM decode, CTRL/SEL/DWELL storage and registered read mux (readLatency = 1).
module mod_sel_regfile
    import mod_ctrl_pkg::*;
#(
    parameter int unsigned DWELL_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    modulator_select_sequencer_if.slave  avs,
    input  logic                         pending,
    input  logic                         auto_active,
    input  logic [7:0]                   active_sig,
    input  logic [3:0]                   active_mod,
    output logic                         auto_en,
    output logic                         sweep_mod,
    output logic [7:0]                   shadow_sig,
    output logic [3:0]                   shadow_mod,
    output logic [DWELL_W-1:0]           dwell,
    output logic                         ctrl_wr,
    output logic                         sel_wr,
    output logic                         wr_auto_en
);

    logic        dwell_wr;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    assign unused_wdata = ^avs.writedata[31:12];

    always_comb begin
        ctrl_wr    = avs.write && (avs.address == ADDR_CTRL);
        sel_wr     = avs.write && (avs.address == ADDR_SEL);
        dwell_wr   = avs.write && (avs.address == ADDR_DWELL);
        wr_auto_en = avs.writedata[0];
    end

    always_comb begin
        rd_mux = 32'd0;
        unique case (avs.address)
            ADDR_CTRL:  rd_mux = {30'd0, sweep_mod, auto_en};
            ADDR_SEL:   rd_mux = {20'd0, shadow_mod, shadow_sig};
            ADDR_DWELL: rd_mux = 32'(dwell);
            ADDR_STAT:  rd_mux = {12'd0, active_mod, active_sig, 6'd0, auto_active, pending};
            default:    rd_mux = 32'd0;
        endcase
    end

    // Reads sample the pre-write contents, so a same-cycle read/write returns the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            auto_en      <= 1'b0;
            sweep_mod    <= 1'b0;
            shadow_sig   <= 8'd0;
            shadow_mod   <= 4'd0;
            dwell        <= DWELL_W'(1);
            avs.readdata <= 32'd0;
        end else begin
            if (ctrl_wr) begin
                auto_en   <= avs.writedata[0];
                sweep_mod <= avs.writedata[1];
            end
            if (sel_wr) begin
                shadow_sig <= avs.writedata[7:0];
                shadow_mod <= avs.writedata[11:8];
            end
            if (dwell_wr) begin
                dwell <= avs.writedata[DWELL_W-1:0];
            end
            if (avs.read) begin
                avs.readdata <= rd_mux;
            end
        end
    end

endmodule

// File: rtl/modulator_select_sequencer.sv
// Sequencer FSM: commits shadowed selections on phase_sync and optionally sweeps
// waveform/modulation every DWELL sync pulses.
module modulator_select_sequencer
    import mod_ctrl_pkg::*;
#(
    parameter int unsigned DWELL_W = 16,
    parameter int unsigned NUM_SIG = 4,
    parameter int unsigned NUM_MOD = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    modulator_select_sequencer_if.slave  avs,
    input  logic                         phase_sync,
    output logic [7:0]                   signal_selector,
    output logic [3:0]                   modulation_selector,
    output logic                         commit_pulse
);

    seq_state_e           state;
    logic                 pending;
    logic [DWELL_W-1:0]   dwell_cnt;

    logic                 auto_en;
    logic                 sweep_mod;
    logic [7:0]           shadow_sig;
    logic [3:0]           shadow_mod;
    logic [DWELL_W-1:0]   dwell;
    logic                 ctrl_wr;
    logic                 sel_wr;
    logic                 wr_auto_en;

    logic [DWELL_W-1:0]   dwell_eff;
    logic                 step_due;
    logic                 sig_wrap;
    logic [7:0]           sig_step;
    logic [3:0]           mod_step;

    mod_sel_regfile #(
        .DWELL_W (DWELL_W)
    ) u_regfile (
        .clk         (clk),
        .reset       (reset),
        .avs         (avs),
        .pending     (pending),
        .auto_active (state == AUTO),
        .active_sig  (signal_selector),
        .active_mod  (modulation_selector),
        .auto_en     (auto_en),
        .sweep_mod   (sweep_mod),
        .shadow_sig  (shadow_sig),
        .shadow_mod  (shadow_mod),
        .dwell       (dwell),
        .ctrl_wr     (ctrl_wr),
        .sel_wr      (sel_wr),
        .wr_auto_en  (wr_auto_en)
    );

    // Out-of-range indices loaded from SEL act as a wrap point in the sweep.
    always_comb begin
        dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;
        step_due  = ({1'b0, dwell_cnt} + 1'b1) >= {1'b0, dwell_eff};
        sig_wrap  = signal_selector >= 8'(NUM_SIG - 1);
        sig_step  = sig_wrap ? 8'd0 : signal_selector + 8'd1;
        mod_step  = modulation_selector;
        if (sweep_mod && sig_wrap) begin
            mod_step = (modulation_selector >= 4'(NUM_MOD - 1)) ? 4'd0
                                                               : modulation_selector + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= MANUAL;
            pending             <= 1'b0;
            dwell_cnt           <= '0;
            signal_selector     <= 8'd0;
            modulation_selector <= 4'd0;
            commit_pulse        <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            unique case (state)
                MANUAL: begin
                    if (sel_wr) begin
                        pending <= 1'b1;
                        state   <= ARMED;
                    end else if (ctrl_wr && wr_auto_en) begin
                        dwell_cnt <= '0;
                        state     <= AUTO;
                    end
                end
                ARMED: begin
                    if (phase_sync) begin
                        signal_selector     <= shadow_sig;
                        modulation_selector <= shadow_mod;
                        commit_pulse        <= 1'b1;
                        pending             <= sel_wr;
                        dwell_cnt           <= '0;
                        if (auto_en) begin
                            state <= AUTO;
                        end else if (!sel_wr) begin
                            state <= MANUAL;
                        end
                    end else if (sel_wr) begin
                        pending <= 1'b1;
                    end
                end
                AUTO: begin
                    if (phase_sync && pending) begin
                        signal_selector     <= shadow_sig;
                        modulation_selector <= shadow_mod;
                        commit_pulse        <= 1'b1;
                        dwell_cnt           <= '0;
                        pending             <= sel_wr;
                    end else begin
                        if (phase_sync) begin
                            if (step_due) begin
                                signal_selector     <= sig_step;
                                modulation_selector <= mod_step;
                                commit_pulse        <= 1'b1;
                                dwell_cnt           <= '0;
                            end else begin
                                dwell_cnt <= dwell_cnt + 1'b1;
                            end
                        end
                        if (sel_wr) begin
                            pending <= 1'b1;
                        end
                    end
                    if (ctrl_wr && !wr_auto_en) begin
                        state <= ((pending && !phase_sync) || sel_wr) ? ARMED : MANUAL;
                    end
                end
                default: state <= MANUAL;
            endcase
        end
    end

endmodule

// File: tb/tb_modulator_select_sequencer.sv
// Directed + randomized bench for modulator_select_sequencer against a transaction-level model.
module tb_modulator_select_sequencer;
    import mod_ctrl_pkg::*;

    localparam int unsigned NUM_SIG = 4;
    localparam int unsigned NUM_MOD = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       phase_sync;
    logic [7:0] signal_selector;
    logic [3:0] modulation_selector;
    logic       commit_pulse;

    modulator_select_sequencer_if avs ();

    modulator_select_sequencer #(
        .DWELL_W (16),
        .NUM_SIG (NUM_SIG),
        .NUM_MOD (NUM_MOD)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .avs                 (avs),
        .phase_sync          (phase_sync),
        .signal_selector     (signal_selector),
        .modulation_selector (modulation_selector),
        .commit_pulse        (commit_pulse)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_commits = 0;

    // Reference model state: what software has written and what the mux should see.
    logic [7:0]  m_sig, m_sh_sig;
    logic [3:0]  m_mod, m_sh_mod;
    logic [1:0]  m_ctrl;
    bit          m_pending, m_auto;
    int unsigned m_dwell, m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_sig = 0; m_mod = 0; m_sh_sig = 0; m_sh_mod = 0; m_ctrl = 0;
        m_pending = 0; m_auto = 0; m_dwell = 1; m_cnt = 0;
    endtask

    task automatic m_sync(output bit c);
        int unsigned eff;
        bit wrap;
        c = 0;
        if (m_pending) begin
            m_sig = m_sh_sig; m_mod = m_sh_mod;
            m_pending = 0; m_cnt = 0; m_auto = m_ctrl[0]; c = 1;
        end else if (m_auto) begin
            eff = (m_dwell == 0) ? 1 : m_dwell;
            m_cnt++;
            if (m_cnt >= eff) begin
                m_cnt = 0;
                c = 1;
                wrap = (int'(m_sig) >= NUM_SIG - 1);
                m_sig = wrap ? 8'd0 : m_sig + 8'd1;
                if (m_ctrl[1] && wrap) m_mod = (int'(m_mod) >= NUM_MOD - 1) ? 4'd0 : m_mod + 4'd1;
            end
        end
    endtask

    task automatic m_write(input logic [1:0] a, input logic [31:0] d);
        case (a)
            ADDR_CTRL: begin
                m_ctrl = d[1:0];
                if (d[0] && !m_auto && !m_pending) begin
                    m_auto = 1; m_cnt = 0;
                end else if (!d[0]) begin
                    m_auto = 0;
                end
            end
            ADDR_SEL: begin
                m_sh_sig = d[7:0]; m_sh_mod = d[11:8]; m_pending = 1;
            end
            ADDR_DWELL: m_dwell = d[15:0];
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input bit exp_commit);
        chk({tag, ".sig"}, 32'(signal_selector), 32'(m_sig));
        chk({tag, ".mod"}, 32'(modulation_selector), 32'(m_mod));
        chk({tag, ".commit"}, 32'(commit_pulse), 32'(exp_commit));
        if (commit_pulse) n_commits++;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input bit with_sync);
        bit c;
        c = 0;
        avs.address = a; avs.writedata = d; avs.write = 1'b1; phase_sync = with_sync;
        tick();
        avs.write = 1'b0; phase_sync = 1'b0;
        if (with_sync) m_sync(c);
        m_write(a, d);
        check_outputs(with_sync ? "wr_sync" : "wr", c);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs.address = a; avs.read = 1'b1;
        tick();
        avs.read = 1'b0;
        d = avs.readdata;
        check_outputs("rd", 1'b0);
    endtask

    task automatic sync_pulse(input string tag);
        bit c;
        phase_sync = 1'b1;
        tick();
        phase_sync = 1'b0;
        m_sync(c);
        check_outputs(tag, c);
    endtask

    task automatic check_stat(input string tag);
        logic [31:0] d;
        rd(ADDR_STAT, d);
        chk(tag, d, {12'd0, m_mod, m_sig, 6'd0, m_auto, m_pending});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        int unsigned op;

        reset = 1'b1; phase_sync = 1'b0;
        avs.address = '0; avs.write = 1'b0; avs.writedata = '0; avs.read = 1'b0;
        tick(); tick();
        reset = 1'b0;
        m_reset();

        // Reset values of every register and output.
        check_outputs("reset", 1'b0);
        rd(ADDR_CTRL, d);  chk("reset.ctrl", d, 32'd0);
        rd(ADDR_SEL, d);   chk("reset.sel", d, 32'd0);
        rd(ADDR_DWELL, d); chk("reset.dwell", d, 32'd1);
        rd(ADDR_STAT, d);  chk("reset.stat", d, 32'd0);

        // Manual commit waits for phase_sync.
        wr(ADDR_SEL, 32'h0102, 1'b0);
        repeat (50) tick();
        check_outputs("t2.hold", 1'b0);
        check_stat("t2.stat_pending");
        sync_pulse("t2.commit");
        chk("t2.sig_abs", 32'(signal_selector), 32'd2);
        chk("t2.mod_abs", 32'(modulation_selector), 32'd1);
        chk("t2.commit_abs", 32'(commit_pulse), 32'd1);
        check_stat("t2.stat_clear");
        tick();
        check_outputs("t2.pulse_end", 1'b0);
        rd(ADDR_SEL, d); chk("t2.sel_rd", d, 32'h0102);

        // Auto sweep with modulation stepping.
        wr(ADDR_DWELL, 32'd3, 1'b0);
        wr(ADDR_CTRL, 32'h3, 1'b0);
        rd(ADDR_CTRL, d); chk("t3.ctrl_rd", d, 32'h3);
        n_commits = 0;
        for (int i = 0; i < 40; i++) sync_pulse("t3.sweep");
        chk("t3.commits", 32'(n_commits), 32'd13);
        check_stat("t3.stat");

        // DWELL 0 behaves as 1; modulation fixed without sweep_mod.
        wr(ADDR_CTRL, 32'h0, 1'b0);
        wr(ADDR_DWELL, 32'd0, 1'b0);
        wr(ADDR_CTRL, 32'h1, 1'b0);
        n_commits = 0;
        for (int i = 0; i < 6; i++) sync_pulse("t4.step");
        chk("t4.commits", 32'(n_commits), 32'd6);

        // Same-cycle write and sync commit the old shadow.
        wr(ADDR_CTRL, 32'h0, 1'b0);
        wr(ADDR_SEL, 32'h0001, 1'b0);
        wr(ADDR_SEL, 32'h0302, 1'b1);
        chk("t5.old_sig", 32'(signal_selector), 32'd1);
        check_stat("t5.stat_pending");
        sync_pulse("t5.new");
        chk("t5.new_sig", 32'(signal_selector), 32'd2);
        chk("t5.new_mod", 32'(modulation_selector), 32'd3);

        // Reset while armed discards the pending shadow.
        wr(ADDR_SEL, 32'h0203, 1'b0);
        reset = 1'b1; phase_sync = 1'b1;
        tick(); tick();
        reset = 1'b0; phase_sync = 1'b0;
        m_reset();
        check_outputs("t6.after_reset", 1'b0);
        check_stat("t6.stat");
        sync_pulse("t6.no_commit");
        chk("t6.commit_abs", 32'(commit_pulse), 32'd0);

        // Randomized mix of register writes, syncs and status reads.
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 9);
            if (op <= 1) begin
                d = {20'd0, 4'($urandom_range(0, 3)), 8'($urandom_range(0, 5))};
                wr(ADDR_SEL, d, 1'b0);
            end else if (op == 2) begin
                wr(ADDR_CTRL, 32'($urandom_range(0, 3)), 1'b0);
            end else if (op == 3 && !m_auto) begin
                wr(ADDR_DWELL, 32'($urandom_range(0, 3)), 1'b0);
            end else if (op == 8) begin
                check_stat("rand.stat");
            end else if (op == 9) begin
                tick();
                check_outputs("rand.idle", 1'b0);
            end else begin
                sync_pulse("rand.sync");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
